shift_deserializer: RTL
=======================

SHIFT_DESERIALIZER -- requirements
Module: shift_deserializer

Interface
REQ-001 Parameter WIDTH, default 8, word length in bits (legal range 2..32).
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low; one clock only.
REQ-004 start  input  1  synchronous frame start; latches dir, clears partial word.
REQ-005 stop  input  1  synchronous abort; returns block to idle, discards partial word.
REQ-006 dir  input  1  bit order, sampled on start: 0 = LSB-first, 1 = MSB-first.
REQ-007 sin  input  1  serial data bit.
REQ-008 sin_valid  input  1  qualifies sin; one bit accepted per cycle when high in SHIFT.
REQ-009 dout_ready  input  1  consumer accepts dout when high with dout_valid.
REQ-010 clr_ovr  input  1  synchronous clear of overrun flag.
REQ-011 dout  output  WIDTH  completed word, registered.
REQ-012 dout_valid  output  1  dout holds an unconsumed word.
REQ-013 overrun  output  1  sticky: a completed word was dropped.
REQ-014 busy  output  1  high in SHIFT state.
REQ-015 bit_cnt  output  clog2(WIDTH)+1  bits accepted in current word.

Function
REQ-016 FSM states SHIFT_IDLE and SHIFT_RX; busy = (state == SHIFT_RX).
REQ-017 IDLE: start=1 and stop=0 -> RX, bit_cnt=0, shift register=0, dir latched; sin_valid ignored that cycle.
REQ-018 RX, sin_valid=1: dir=0 -> shreg <= {sin, shreg[WIDTH-1:1]}; dir=1 -> shreg <= {shreg[WIDTH-2:0], sin}; bit_cnt increments.
REQ-019 RX, sin_valid=0: shreg and bit_cnt hold.
REQ-020 Word completes on edge accepting bit with bit_cnt == WIDTH-1; the completed word (shreg including that bit) is delivered same edge; bit_cnt returns to 0, state stays RX (back-to-back words, no gap cycle).
REQ-021 Delivery: if dout_valid=0, or dout_valid=1 and dout_ready=1 on that edge, dout <= word and dout_valid <= 1.
REQ-022 Delivery with dout_valid=1 and dout_ready=0: word dropped, dout unchanged, overrun <= 1.
REQ-023 dout_valid=1 and dout_ready=1 with no delivery: dout_valid <= 0; dout holds last value.
REQ-024 dout and dout_valid stable while dout_valid=1 and dout_ready=0.
REQ-025 RX, start=1 (stop=0): restart frame -- bit_cnt=0, shreg=0, dir relatched; any sin_valid bit that cycle discarded; no delivery.
REQ-026 stop=1 in any state: next state IDLE, bit_cnt=0, shreg=0; stop wins over start and over word completion; dout/dout_valid/overrun unaffected.
REQ-027 clr_ovr=1 clears overrun unless an overrun event occurs same cycle; set wins.
REQ-028 Latency: last bit at edge N -> dout_valid high after edge N; no combinational path from sin to outputs.

Reset
REQ-029 rst_n=0 asynchronously forces IDLE, dout=0, dout_valid=0, overrun=0, bit_cnt=0, shreg=0, latched dir=0, busy=0.
REQ-030 Reset mid-word discards partial word; block waits for start after rst_n release.

Verification (WIDTH=8)
REQ-031 Reset: drive rst_n=0 mid-word with dout_valid=1 -> all outputs 0 immediately, before next clk edge.
REQ-032 MSB-first: start with dir=1, then bits 1,0,1,0,0,1,1,0 on consecutive cycles -> dout=8'hA6, dout_valid rises on 8th-bit edge.
REQ-033 LSB-first: same stream with dir=0 -> dout=8'h65; bit_cnt steps 1..7 then 0.
REQ-034 Overrun: dout_ready=0, send 8'hA6 then 8'h3C -> dout stays 8'hA6, overrun=1; clr_ovr pulse -> overrun=0; dout_ready pulse -> dout_valid=0.
REQ-035 Back-to-back: dout_ready=1, 24 continuous bits -> three dout_valid pulses 8 cycles apart, no bit lost.
REQ-036 Abort: 3 bits then start -> partial discarded, next 8 bits form word; stop asserted with 8th bit -> no delivery, busy=0.

Source files
------------

// File: rtl/shift_deserializer_if.sv
// Handshake and data bundle between a serial-bit producer and shift_deserializer.
// The DUT sits on the slave modport; whoever drives the serial stream uses master.
interface shift_deserializer_if #(
    parameter int unsigned WIDTH = 8
);
    localparam int unsigned CNT_W = $clog2(WIDTH) + 1;

    logic             start;
    logic             stop;
    logic             dir;
    logic             sin;
    logic             sin_valid;
    logic             dout_ready;
    logic             clr_ovr;
    logic [WIDTH-1:0] dout;
    logic             dout_valid;
    logic             overrun;
    logic             busy;
    logic [CNT_W-1:0] bit_cnt;

    modport master (
        output start,
        output stop,
        output dir,
        output sin,
        output sin_valid,
        output dout_ready,
        output clr_ovr,
        input  dout,
        input  dout_valid,
        input  overrun,
        input  busy,
        input  bit_cnt
    );

    modport slave (
        input  start,
        input  stop,
        input  dir,
        input  sin,
        input  sin_valid,
        input  dout_ready,
        input  clr_ovr,
        output dout,
        output dout_valid,
        output overrun,
        output busy,
        output bit_cnt
    );
endinterface

// File: rtl/shift_deserializer.sv
// Serial-to-parallel deserializer with selectable bit order, a one-word output
// register with valid/ready handoff, and a sticky overrun flag for dropped words.
module shift_deserializer #(
    parameter int unsigned WIDTH = 8
) (
    input logic                  clk,
    input logic                  rst_n,
    shift_deserializer_if.slave  bus
);
    localparam int unsigned CNT_W = $clog2(WIDTH) + 1;

    localparam logic [0:0] SHIFT_IDLE = 1'b0;
    localparam logic [0:0] SHIFT_RX   = 1'b1;

    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    logic [0:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic             dir_q, dir_d;
    logic [WIDTH-1:0] dout_q, dout_d;
    logic             valid_q, valid_d;
    logic             ovr_q, ovr_d;

    logic [WIDTH-1:0] shifted;
    logic             deliver;
    logic             ovr_event;

    // Candidate register contents if the incoming bit were accepted this cycle.
    always_comb begin
        if (dir_q) begin
            shifted = {shreg_q[WIDTH-2:0], bus.sin};
        end else begin
            shifted = {bus.sin, shreg_q[WIDTH-1:1]};
        end
    end

    // Frame control: stop beats start, start beats bit acceptance.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        shreg_d = shreg_q;
        dir_d   = dir_q;
        deliver = 1'b0;

        if (bus.stop) begin
            state_d = SHIFT_IDLE;
            cnt_d   = '0;
            shreg_d = '0;
        end else if (bus.start) begin
            state_d = SHIFT_RX;
            cnt_d   = '0;
            shreg_d = '0;
            dir_d   = bus.dir;
        end else if (state_q == SHIFT_RX && bus.sin_valid) begin
            shreg_d = shifted;
            if (cnt_q == LAST_BIT) begin
                deliver = 1'b1;
                cnt_d   = '0;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    // Output word register; a completed word never overwrites an unconsumed one.
    always_comb begin
        dout_d    = dout_q;
        valid_d   = valid_q;
        ovr_event = 1'b0;

        if (deliver) begin
            if (!valid_q || bus.dout_ready) begin
                dout_d  = shifted;
                valid_d = 1'b1;
            end else begin
                ovr_event = 1'b1;
            end
        end else if (valid_q && bus.dout_ready) begin
            valid_d = 1'b0;
        end

        if (ovr_event) begin
            ovr_d = 1'b1;
        end else if (bus.clr_ovr) begin
            ovr_d = 1'b0;
        end else begin
            ovr_d = ovr_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= SHIFT_IDLE;
            cnt_q   <= '0;
            shreg_q <= '0;
            dir_q   <= 1'b0;
            dout_q  <= '0;
            valid_q <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            shreg_q <= shreg_d;
            dir_q   <= dir_d;
            dout_q  <= dout_d;
            valid_q <= valid_d;
            ovr_q   <= ovr_d;
        end
    end

    assign bus.dout       = dout_q;
    assign bus.dout_valid = valid_q;
    assign bus.overrun    = ovr_q;
    assign bus.busy       = (state_q == SHIFT_RX);
    assign bus.bit_cnt    = cnt_q;
endmodule
